// File: rtl/ef_tmr32_pkg.sv
// rtl/ef_tmr32_pkg.sv - shared encodings and helpers for the ef_tmr32 timer
package ef_tmr32_pkg;

    // Tick source selection (clk_src)
    localparam logic [3:0] CLK_DIV1   = 4'd0;
    localparam logic [3:0] CLK_DIV2   = 4'd1;
    localparam logic [3:0] CLK_DIV4   = 4'd2;
    localparam logic [3:0] CLK_DIV8   = 4'd3;
    localparam logic [3:0] CLK_DIV16  = 4'd4;
    localparam logic [3:0] CLK_DIV32  = 4'd5;
    localparam logic [3:0] CLK_DIV64  = 4'd6;
    localparam logic [3:0] CLK_DIV128 = 4'd7;
    localparam logic [3:0] CLK_DIV256 = 4'd8;
    localparam logic [3:0] CLK_EXT    = 4'd9;

    // Capture edge selection (cp_event)
    localparam logic [1:0] CP_NONE = 2'd0;
    localparam logic [1:0] CP_RISE = 2'd1;
    localparam logic [1:0] CP_FALL = 2'd2;
    localparam logic [1:0] CP_BOTH = 2'd3;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    // Low n prescaler bits that must all be ones for a divide-by-2^n tick
    function automatic logic [7:0] div_mask(input logic [3:0] src);
        logic [8:0] m;
        m = (9'd1 << src) - 9'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ef_tmr32_sync_edge.sv
// rtl/ef_tmr32_sync_edge.sv - 2-flop synchronizer with rise/fall edge detect
module ef_tmr32_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic last;

    // Two synchronizing stages plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            last <= 1'b0;
        end else if (!en) begin
            meta <= 1'b0;
            sync <= 1'b0;
            last <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            last <= sync;
        end
    end

    assign rise = sync & ~last;
    assign fall = ~sync & last;

endmodule

// File: rtl/ef_tmr32.sv
// rtl/ef_tmr32.sv - 32-bit timer/counter with PWM, input capture and match
module ef_tmr32
    import ef_tmr32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        ctr_in,
    input  logic [3:0]  clk_src,
    input  logic        tmr_en,
    input  logic        up,
    input  logic        one_shot,
    input  logic [31:0] period,
    input  logic        pwm_en,
    input  logic [31:0] pwm_cmp,
    input  logic        cp_en,
    input  logic [1:0]  cp_event,
    input  logic [31:0] ctr_match,
    output logic [31:0] tmr,
    output logic [31:0] cp_count,
    output logic        to_flag,
    output logic        cp_flag,
    output logic        match_flag,
    output logic        pwm_out
);

    logic [7:0]  prescaler;
    logic        in_rise;
    logic        in_fall;
    logic        tick;

    logic [31:0] init_val;
    logic [31:0] tmr_next;
    logic        at_limit;
    logic        halted;
    logic        halted_next;
    logic        to_next;
    logic        match_next;

    logic [31:0] cp_cnt;
    logic        cp_hit;

    ef_tmr32_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .din   (ctr_in),
        .rise  (in_rise),
        .fall  (in_fall)
    );

    // Free-running prescaler, held at zero while the block is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= 8'd0;
        end else if (!en) begin
            prescaler <= 8'd0;
        end else begin
            prescaler <= prescaler + 8'd1;
        end
    end

    // Tick source selection
    always_comb begin
        tick = 1'b0;
        case (clk_src)
            CLK_DIV1:   tick = 1'b1;
            CLK_DIV2, CLK_DIV4, CLK_DIV8, CLK_DIV16,
            CLK_DIV32, CLK_DIV64, CLK_DIV128, CLK_DIV256:
                tick = ((prescaler & div_mask(clk_src)) == div_mask(clk_src));
            CLK_EXT:    tick = in_rise;
            default:    tick = 1'b0;
        endcase
    end

    assign init_val = up ? 32'd0 : period;
    assign at_limit = up ? (tmr == period) : (tmr == 32'd0);

    // Next timer value, timeout/match pulses and one-shot halt
    always_comb begin
        tmr_next    = tmr;
        halted_next = halted;
        to_next     = 1'b0;
        match_next  = 1'b0;
        if (!tmr_en) begin
            tmr_next    = init_val;
            halted_next = 1'b0;
        end else if (halted) begin
            // A finished one-shot tracks INIT until tmr_en is dropped
            tmr_next = init_val;
        end else if (tick) begin
            if (at_limit) begin
                tmr_next    = init_val;
                to_next     = 1'b1;
                halted_next = one_shot;
            end else if (up) begin
                tmr_next = tmr + 32'd1;
            end else begin
                tmr_next = tmr - 32'd1;
            end
            match_next = (tmr_next == ctr_match);
        end
    end

    // Timer, flag and PWM registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr        <= 32'd0;
            halted     <= 1'b0;
            to_flag    <= 1'b0;
            match_flag <= 1'b0;
            pwm_out    <= 1'b0;
        end else if (!en) begin
            tmr        <= 32'd0;
            halted     <= 1'b0;
            to_flag    <= 1'b0;
            match_flag <= 1'b0;
            pwm_out    <= 1'b0;
        end else begin
            tmr        <= tmr_next;
            halted     <= halted_next;
            to_flag    <= to_next;
            match_flag <= match_next;
            pwm_out    <= pwm_en & tmr_en & (tmr < pwm_cmp);
        end
    end

    // Capture event selection
    always_comb begin
        cp_hit = 1'b0;
        case (cp_event)
            CP_NONE: cp_hit = 1'b0;
            CP_RISE: cp_hit = in_rise;
            CP_FALL: cp_hit = in_fall;
            CP_BOTH: cp_hit = in_rise | in_fall;
        endcase
    end

    // Interval counter and capture register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cp_cnt   <= 32'd0;
            cp_count <= 32'd0;
            cp_flag  <= 1'b0;
        end else if (!en) begin
            cp_cnt   <= 32'd0;
            cp_count <= 32'd0;
            cp_flag  <= 1'b0;
        end else if (!cp_en) begin
            cp_cnt  <= 32'd0;
            cp_flag <= 1'b0;
        end else if (cp_hit) begin
            cp_count <= cp_cnt;
            cp_cnt   <= 32'd0;
            cp_flag  <= 1'b1;
        end else begin
            cp_flag <= 1'b0;
            if (cp_cnt != CNT_MAX) begin
                cp_cnt <= cp_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ef_tmr32.sv
// tb/tb_ef_tmr32.sv - randomized self-checking bench for ef_tmr32
module tb_ef_tmr32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        ctr_in;
    logic [3:0]  clk_src;
    logic        tmr_en;
    logic        up;
    logic        one_shot;
    logic [31:0] period;
    logic        pwm_en;
    logic [31:0] pwm_cmp;
    logic        cp_en;
    logic [1:0]  cp_event;
    logic [31:0] ctr_match;
    logic [31:0] tmr;
    logic [31:0] cp_count;
    logic        to_flag;
    logic        cp_flag;
    logic        match_flag;
    logic        pwm_out;

    always #50 clk = ~clk;

    ef_tmr32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ctr_in     (ctr_in),
        .clk_src    (clk_src),
        .tmr_en     (tmr_en),
        .up         (up),
        .one_shot   (one_shot),
        .period     (period),
        .pwm_en     (pwm_en),
        .pwm_cmp    (pwm_cmp),
        .cp_en      (cp_en),
        .cp_event   (cp_event),
        .ctr_match  (ctr_match),
        .tmr        (tmr),
        .cp_count   (cp_count),
        .to_flag    (to_flag),
        .cp_flag    (cp_flag),
        .match_flag (match_flag),
        .pwm_out    (pwm_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [2:0]  m_seen;        // ctr_in as sampled at the last three edges, [0] newest
    int unsigned m_cycles;      // edges since enable, mod 256
    logic [31:0] m_tmr;
    logic        m_done;
    logic        m_to;
    logic        m_match;
    logic        m_pwm;
    logic [31:0] m_elapsed;
    logic [31:0] m_cpc;
    logic        m_cpf;

    task automatic model_clear();
        m_seen = 3'b000; m_cycles = 0;
        m_tmr = 0; m_done = 0; m_to = 0; m_match = 0; m_pwm = 0;
        m_elapsed = 0; m_cpc = 0; m_cpf = 0;
    endtask

    task automatic model_step();
        logic rise, fall, tk, ev;
        logic [31:0] init;
        int d;
        if (!en) begin
            model_clear();
            return;
        end
        // An edge on ctr_in becomes visible two sampling edges later
        rise = m_seen[1] & ~m_seen[2];
        fall = ~m_seen[1] & m_seen[2];
        m_seen = {m_seen[1:0], ctr_in};
        if (clk_src == 4'd0) tk = 1'b1;
        else if (clk_src <= 4'd8) begin
            d  = 1 << clk_src;
            tk = ((m_cycles % d) == d - 1);
        end else if (clk_src == 4'd9) tk = rise;
        else tk = 1'b0;
        m_cycles = (m_cycles + 1) % 256;

        m_pwm   = pwm_en && tmr_en && (m_tmr < pwm_cmp);
        init    = up ? 32'd0 : period;
        m_to    = 1'b0;
        m_match = 1'b0;
        if (!tmr_en) begin
            m_tmr = init; m_done = 1'b0;
        end else if (m_done) begin
            m_tmr = init;
        end else if (tk) begin
            if ((up && m_tmr == period) || (!up && m_tmr == 0)) begin
                m_tmr = init; m_to = 1'b1; m_done = one_shot;
            end else begin
                m_tmr = up ? m_tmr + 32'd1 : m_tmr - 32'd1;
            end
            m_match = (m_tmr == ctr_match);
        end

        m_cpf = 1'b0;
        if (!cp_en) m_elapsed = 0;
        else begin
            ev = (cp_event == 2'd1 && rise) || (cp_event == 2'd2 && fall) ||
                 (cp_event == 2'd3 && (rise || fall));
            if (ev) begin
                m_cpc = m_elapsed; m_elapsed = 0; m_cpf = 1'b1;
            end else if (m_elapsed != 32'hFFFF_FFFF) begin
                m_elapsed = m_elapsed + 32'd1;
            end
        end
    endtask

    task automatic compare_all();
        check32("tmr",        tmr,        m_tmr);
        check32("cp_count",   cp_count,   m_cpc);
        check32("to_flag",    {31'd0, to_flag},    {31'd0, m_to});
        check32("cp_flag",    {31'd0, cp_flag},    {31'd0, m_cpf});
        check32("match_flag", {31'd0, match_flag}, {31'd0, m_match});
        check32("pwm_out",    {31'd0, pwm_out},    {31'd0, m_pwm});
    endtask

    int tog_half = 0;
    int tog_cnt  = 0;

    // Starts and ends at a falling edge
    task automatic one_cycle();
        if (tog_half != 0) begin
            if (tog_cnt <= 0) begin
                ctr_in  = ~ctr_in;
                tog_cnt = tog_half + $urandom_range(0, 1);
            end else tog_cnt--;
        end
        @(posedge clk);
        if (rst_n) model_step();
        else model_clear();
        #1 compare_all();
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int len;
        int kind;
        rst_n = 0; en = 0; ctr_in = 0; clk_src = 0; tmr_en = 0; up = 0; one_shot = 0;
        period = 0; pwm_en = 0; pwm_cmp = 0; cp_en = 0; cp_event = 0; ctr_match = 0;
        model_clear();
        @(negedge clk);
        one_cycle();
        one_cycle();
        rst_n = 1;

        // Down one-shot, period 20, divide-by-2: timeout on the 21st tick
        en = 1; clk_src = 4'd1; up = 0; one_shot = 1; period = 32'd20; ctr_match = 32'd7;
        one_cycle();
        one_cycle();
        tmr_en = 1;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            one_cycle();
            if (to_flag) begin
                lat = i;
                break;
            end
        end
        check32("oneshot_latency", {31'd0, (lat == 41 || lat == 42)}, 32'd1);
        for (int i = 0; i < 10; i++) one_cycle();
        check32("oneshot_hold", tmr, 32'd20);

        for (int r = 0; r < 36; r++) begin
            kind = r % 6;
            tmr_en = 0; pwm_en = 0; cp_en = 0; cp_event = 0; one_shot = 0; tog_half = 0;
            clk_src = 4'($urandom_range(0, 3));
            up      = 1'($urandom_range(0, 1));
            period  = $urandom_range(0, 25);
            case (kind)
                0: begin up = 0; one_shot = 1; end
                1: begin up = 1; one_shot = 0; end
                2: begin up = 1; pwm_en = 1; end
                3: begin cp_en = 1; cp_event = 2'(1 + (r / 6) % 3); tog_half = $urandom_range(3, 12); end
                4: begin clk_src = 4'd9; up = 1; period = 32'd30; tog_half = $urandom_range(2, 8); end
                default: begin
                    clk_src  = 4'($urandom_range(0, 15));
                    one_shot = 1'($urandom_range(0, 1));
                    pwm_en   = 1'($urandom_range(0, 1));
                    cp_en    = 1'($urandom_range(0, 1));
                    cp_event = 2'($urandom_range(0, 3));
                    tog_half = $urandom_range(0, 6);
                    case ($urandom_range(0, 3))
                        0: period = 32'd0;
                        1: period = 32'hFFFF_FFFF;
                        2: period = 32'hFFFF_FFFE;
                        default: period = $urandom;
                    endcase
                end
            endcase
            pwm_cmp   = (period < 32'd100) ? $urandom_range(0, period + 2) : $urandom;
            ctr_match = (period < 32'd100) ? $urandom_range(0, period) : $urandom;
            one_cycle();
            one_cycle();
            tmr_en = 1;
            len = $urandom_range(150, 400);
            for (int i = 0; i < len; i++) begin
                if (i == len / 2 && r % 4 == 3) begin
                    en = 0;
                    for (int k = 0; k < 3; k++) one_cycle();
                    en = 1;
                end
                if (i == len / 2 && r % 4 == 1) begin
                    #20 rst_n = 0;
                    #1 model_clear();
                    compare_all();
                    @(negedge clk);
                    for (int k = 0; k < 3; k++) one_cycle();
                    rst_n = 1;
                end
                one_cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
